motor_sequencer: RTL

- Supervisory controller for the encoder → PI loop → PWM motor datapath.
- Owns the `motor_on` gate and the `desired_period` setpoint fed to the PI loop.
- Sequences the motor through spin-up, a rate-limited setpoint ramp, regulated run and coast-down.
- Detects spin-up failure and stall, latches a fault, and holds the motor off until the fault is cleared.

---
 rtl/motor_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/motor_sequencer.sv
// rtl/motor_sequencer.sv - supervisory spin-up/ramp/run/coast sequencer with stall and spin-up fault latching
module motor_sequencer #(
  parameter logic signed [31:0] START_PERIOD   = 32'sh0010_0000,
  parameter logic signed [31:0] RAMP_STEP      = 32'sh0000_0100,
  parameter int                 RAMP_DIV       = 1024,
  parameter logic signed [31:0] SPIN_PERIOD    = 32'sh0020_0000,
  parameter int                 SPINUP_TIMEOUT = 50_000_000,
  parameter int                 STALL_CYCLES   = 8_000_000,
  parameter logic signed [31:0] LOCK_TOL       = 32'sh0000_0200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               fault_clear,
  input  logic               enc_edge,
  input  logic signed [31:0] period,
  input  logic signed [31:0] target_period,
  output logic               motor_on,
  output logic signed [31:0] desired_period,
  output logic [2:0]         state,
  output logic               at_speed,
  output logic               fault,
  output logic [1:0]         fault_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPINUP = 3'd1,
    RAMP   = 3'd2,
    RUN    = 3'd3,
    COAST  = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        wd_q, wd_d, spin_q, spin_d, tick_q, tick_d;
  logic signed [31:0] desired_q, desired_d;
  logic [1:0]         code_q, code_d;
  logic               motor_on_q, at_speed_q, fault_q;
  logic               motor_on_d, at_speed_d, fault_d;

  // The post-reset sentinel and negative periods must never look like a valid measurement.
  logic               period_valid, spinning, wd_stall, tick;
  logic signed [32:0] ramp_diff, lock_diff;
  logic [32:0]        ramp_mag, lock_mag;

  assign period_valid = !period[31] && (period != 32'sh7FFF_FFFF);
  assign spinning     = enc_edge && period_valid && (period <= SPIN_PERIOD);
  assign wd_stall     = !enc_edge && (wd_q >= 32'(STALL_CYCLES - 1));
  assign tick         = (tick_q == 32'(RAMP_DIV - 1));
  assign ramp_diff    = {target_period[31], target_period} - {desired_q[31], desired_q};
  assign ramp_mag     = ramp_diff[32] ? 33'(-ramp_diff) : 33'(ramp_diff);
  assign lock_diff    = {period[31], period} - {desired_d[31], desired_d};
  assign lock_mag     = lock_diff[32] ? 33'(-lock_diff) : 33'(lock_diff);

  always_comb begin
    state_d   = state_q;
    desired_d = desired_q;
    code_d    = code_q;
    tick_d    = 32'd0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d   = SPINUP;
          desired_d = START_PERIOD;
        end
      end
      SPINUP: begin
        if (spin_q >= 32'(SPINUP_TIMEOUT - 1)) begin
          state_d = FAULT;
          code_d  = 2'd1;
        end else if (stop) begin
          state_d = COAST;
        end else if (spinning) begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (wd_stall) begin
          state_d = FAULT;
          code_d  = 2'd2;
        end else if (stop) begin
          state_d = COAST;
        end else begin
          tick_d = tick ? 32'd0 : tick_q + 32'd1;
          if (tick) begin
            if (ramp_mag <= {1'b0, RAMP_STEP}) begin
              desired_d = target_period;
              state_d   = RUN;
            end else if (ramp_diff[32]) begin
              desired_d = desired_q - RAMP_STEP;
            end else begin
              desired_d = desired_q + RAMP_STEP;
            end
          end
        end
      end
      RUN: begin
        if (wd_stall) begin
          state_d = FAULT;
          code_d  = 2'd2;
        end else if (stop) begin
          state_d = COAST;
        end else if (target_period != desired_q) begin
          state_d = RAMP;
        end
      end
      COAST: begin
        if (wd_stall) begin
          state_d   = IDLE;
          desired_d = START_PERIOD;
        end
      end
      FAULT: begin
        if (fault_clear && !start) begin
          state_d   = IDLE;
          code_d    = 2'd0;
          desired_d = START_PERIOD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog restarts on every encoder edge and on every state entry.
  assign wd_d       = (enc_edge || (state_d != state_q)) ? 32'd0 :
                      (wd_q >= 32'(STALL_CYCLES)) ? 32'(STALL_CYCLES) : wd_q + 32'd1;
  assign spin_d     = ((state_q == SPINUP) && (state_d == SPINUP)) ? spin_q + 32'd1 : 32'd0;
  assign motor_on_d = (state_d == SPINUP) || (state_d == RAMP) || (state_d == RUN);
  assign at_speed_d = (state_d == RUN) && period_valid && (lock_mag <= {1'b0, LOCK_TOL});
  assign fault_d    = (state_d == FAULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wd_q       <= 32'd0;
      spin_q     <= 32'd0;
      tick_q     <= 32'd0;
      desired_q  <= START_PERIOD;
      code_q     <= 2'd0;
      motor_on_q <= 1'b0;
      at_speed_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      spin_q     <= spin_d;
      tick_q     <= tick_d;
      desired_q  <= desired_d;
      code_q     <= code_d;
      motor_on_q <= motor_on_d;
      at_speed_q <= at_speed_d;
      fault_q    <= fault_d;
    end
  end

  assign state          = state_q;
  assign desired_period = desired_q;
  assign fault_code     = code_q;
  assign motor_on       = motor_on_q;
  assign at_speed       = at_speed_q;
  assign fault          = fault_q;

endmodule
